regbank4_scan: RTL

Four-entry register bank with an auto-scanning select sequencer. It sits directly upstream of the 4-bit 4:1 mux stage: its four register outputs drive the mux data inputs `in0`..`in3`, and its `s` output drives the mux select. A valid/ready handshake lets the mux consumer pace the scan. A single write port loads the registers.

---
 rtl/regbank4_scan.sv | 117 +++++++++++
 1 files changed

// File: rtl/regbank4_scan.sv
// regbank4_scan: four-entry register bank with a valid/ready-paced select scanner.
// q0..q3 feed the downstream 4:1 mux data inputs and s drives its select.
// Optional feature: define REGBANK_WRITE_BYPASS_EN so that a write shows on qN in the same cycle.
module regbank4_scan #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             start,
  input  logic             ready,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [1:0]       s,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] LAST_IDX = 2'd3;

  logic [WIDTH-1:0] regs [4];
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       s_nxt;
  logic             valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             hs;

  // Register file: single write port, writable in every scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef REGBANK_WRITE_BYPASS_EN
  // Same-cycle forwarding of the write data onto the addressed output.
  assign q0 = (we && (waddr == 2'd0)) ? wdata : regs[0];
  assign q1 = (we && (waddr == 2'd1)) ? wdata : regs[1];
  assign q2 = (we && (waddr == 2'd2)) ? wdata : regs[2];
  assign q3 = (we && (waddr == 2'd3)) ? wdata : regs[3];
`else
  // Purely registered outputs.
  assign q0 = regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
`endif

  // Handshake: the selected entry is taken by the consumer this cycle.
  assign hs = valid & ready;

  // State and registered scan outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      s     <= 2'd0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next state and next output values; outputs are decoded from the next state so they leave flops.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    case (state)
      ST_IDLE: begin
        s_nxt = 2'd0;
        if (start) begin
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hs) begin
          if (s == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            s_nxt = s + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        s_nxt     = 2'd0;
      end
      default: begin
        state_nxt = ST_IDLE;
        s_nxt     = 2'd0;
      end
    endcase
    valid_nxt = (state_nxt == ST_SCAN);
    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);
  end

endmodule
